// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The loader takes the slave view; the stream source/memory side takes master.
interface imem_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory boot loader: parses MAGIC / count / payload / checksum from a
// byte stream, writes words into instruction memory and releases the core on success.
module imem_loader #(
    parameter int unsigned WORDS = 4096,
    parameter logic [31:0] MAGIC = 32'h50434F31
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         restart,
    imem_loader_if.slave bus,
    output logic         cpu_rst_n,
    output logic         busy,
    output logic         done,
    output logic         error
);

    // Wide enough to hold WORDS itself, so the word count never wraps.
    localparam int unsigned IdxW = $clog2(WORDS + 1);

    typedef enum logic [2:0] {
        StMagic,
        StLen,
        StData,
        StCsum,
        StDone,
        StErr
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      hdr_cnt_q, hdr_cnt_d;
    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic [31:0]     asm_q, asm_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [IdxW-1:0] count_q, count_d;
    logic [7:0]      csum_q, csum_d;
    logic            mem_we_q, mem_we_d;
    logic [31:0]     mem_addr_q, mem_addr_d;
    logic [31:0]     mem_wdata_q, mem_wdata_d;

    logic            xfer;
    logic [31:0]     asm_next;
    logic [7:0]      magic_byte;
    logic [7:0]      csum_final;
    logic [IdxW-1:0] idx_inc;

    always_comb begin
        unique case (hdr_cnt_q)
            2'd0:    magic_byte = MAGIC[7:0];
            2'd1:    magic_byte = MAGIC[15:8];
            2'd2:    magic_byte = MAGIC[23:16];
            default: magic_byte = MAGIC[31:24];
        endcase
    end

    always_comb begin
        bus.in_ready = (state_q == StMagic) || (state_q == StLen) ||
                       (state_q == StData)  || (state_q == StCsum);
        busy         = (state_q == StLen) || (state_q == StData) || (state_q == StCsum);
        done         = (state_q == StDone);
        error        = (state_q == StErr);
        cpu_rst_n    = (state_q == StDone);
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    assign xfer       = bus.in_valid && bus.in_ready;
    // Little-endian assembly: each new byte enters at the top and slides down.
    assign asm_next   = {bus.in_data, asm_q[31:8]};
    assign csum_final = csum_q + bus.in_data;
    assign idx_inc    = idx_q + {{(IdxW-1){1'b0}}, 1'b1};

    always_comb begin
        state_d     = state_q;
        hdr_cnt_d   = hdr_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        asm_d       = asm_q;
        idx_d       = idx_q;
        count_d     = count_q;
        csum_d      = csum_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        if (restart) begin
            // Any byte offered in this cycle is dropped; memory is left as is.
            state_d    = StMagic;
            hdr_cnt_d  = '0;
            byte_cnt_d = '0;
            asm_d      = '0;
            idx_d      = '0;
            count_d    = '0;
            csum_d     = '0;
        end else if (xfer) begin
            unique case (state_q)
                StMagic: begin
                    if (bus.in_data == magic_byte) begin
                        if (hdr_cnt_q == 2'd3) begin
                            state_d   = StLen;
                            hdr_cnt_d = '0;
                        end else begin
                            hdr_cnt_d = hdr_cnt_q + 2'd1;
                        end
                    end else begin
                        // A failed match may itself be the start of a new header.
                        hdr_cnt_d = (bus.in_data == MAGIC[7:0]) ? 2'd1 : 2'd0;
                    end
                end
                StLen: begin
                    asm_d      = asm_next;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (asm_next == 32'd0) begin
                            state_d = StCsum;
                        end else if (asm_next > WORDS) begin
                            state_d = StErr;
                        end else begin
                            state_d = StData;
                            count_d = asm_next[IdxW-1:0];
                            idx_d   = '0;
                        end
                    end
                end
                StData: begin
                    asm_d      = asm_next;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    csum_d     = csum_final;
                    if (byte_cnt_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {{(30-IdxW){1'b0}}, idx_q, 2'b00};
                        mem_wdata_d = asm_next;
                        idx_d       = idx_inc;
                        if (idx_inc == count_q) begin
                            state_d = StCsum;
                        end
                    end
                end
                StCsum: begin
                    state_d = (csum_final == 8'd0) ? StDone : StErr;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StMagic;
            hdr_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            asm_q       <= '0;
            idx_q       <= '0;
            count_q     <= '0;
            csum_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            hdr_cnt_q   <= hdr_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            asm_q       <= asm_d;
            idx_q       <= idx_d;
            count_q     <= count_d;
            csum_q      <= csum_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

`ifndef SYNTHESIS
    addr_aligned_a: assert property (@(posedge clk) disable iff (!rst_n)
        bus.mem_addr[1:0] == 2'b00);
    we_single_cycle_a: assert property (@(posedge clk) disable iff (!rst_n)
        bus.mem_we |=> !bus.mem_we);
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Randomised scoreboard bench for imem_loader: a stream-level reference model queues the
// expected memory writes and a separate monitor checks every write strobe against it.
module tb_imem_loader;

    localparam int unsigned WORDS = 4096;
    localparam logic [31:0] MAGIC = 32'h50434F31;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic restart = 1'b0;
    logic cpu_rst_n, busy, done, error;

    imem_loader_if bus();

    imem_loader #(
        .WORDS(WORDS),
        .MAGIC(MAGIC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .restart(restart),
        .bus(bus),
        .cpu_rst_n(cpu_rst_n),
        .busy(busy),
        .done(done),
        .error(error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0]  stream[$];
    logic [63:0] exp_q[$];     // {addr, data} of each expected write
    int          we_cycles[$];
    int          cyc = 0;
    logic [31:0] last_addr = 32'd0;
    logic [31:0] last_data = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest expected write; between strobes
    // the write port must hold the last written address/data.
    always @(negedge clk) begin
        logic [63:0] e;
        cyc++;
        if (!rst_n) begin
            last_addr = 32'd0;
            last_data = 32'd0;
        end else if (bus.mem_we) begin
            we_cycles.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("mem_addr", bus.mem_addr, e[63:32]);
                check("mem_wdata", bus.mem_wdata, e[31:0]);
                last_addr = e[63:32];
                last_data = e[31:0];
            end
        end else begin
            check("addr_hold", bus.mem_addr, last_addr);
            check("wdata_hold", bus.mem_wdata, last_data);
        end
    end

    // Reference model over the whole stream. outcome: 0 incomplete, 1 done, 2 error.
    // consumed is the number of bytes the loader should accept.
    task automatic model_push(output int outcome, output int consumed);
        int k = 0;
        int i = 0;
        int total = 0;
        int unsigned n;
        logic [31:0] word;
        outcome  = 0;
        consumed = stream.size();
        while (i < stream.size() && k < 4) begin
            if (stream[i] == MAGIC[8*k +: 8]) k++;
            else k = (stream[i] == MAGIC[7:0]) ? 1 : 0;
            i++;
        end
        if (k < 4 || i + 4 > stream.size()) return;
        n = {stream[i+3], stream[i+2], stream[i+1], stream[i]};
        i += 4;
        if (n > WORDS) begin
            outcome  = 2;
            consumed = i;
            return;
        end
        for (int unsigned w = 0; w < n; w++) begin
            if (i + 4 > stream.size()) return;
            word = {stream[i+3], stream[i+2], stream[i+1], stream[i]};
            exp_q.push_back({w * 4, word});
            total += int'(stream[i]) + int'(stream[i+1]) + int'(stream[i+2]) + int'(stream[i+3]);
            i += 4;
        end
        if (i >= stream.size()) return;
        outcome  = ((total + int'(stream[i])) % 256 == 0) ? 1 : 2;
        consumed = i + 1;
    endtask

    task automatic build_random(input int unsigned n, input bit good, input int prefix);
        int total = 0;
        logic [7:0] b;
        logic [7:0] c;
        stream.delete();
        repeat (prefix) stream.push_back(8'($urandom));
        for (int k = 0; k < 4; k++) stream.push_back(MAGIC[8*k +: 8]);
        for (int k = 0; k < 4; k++) stream.push_back(8'(n >> (8 * k)));
        if (n <= WORDS) begin
            for (int k = 0; k < int'(n) * 4; k++) begin
                b = 8'($urandom);
                total += int'(b);
                stream.push_back(b);
            end
        end
        c = 8'((256 - (total % 256)) % 256);
        if (!good) c = c + 8'($urandom_range(1, 255));
        stream.push_back(c);
    endtask

    task automatic send_byte(input logic [7:0] b, output int waited);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        waited = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            waited++;
            if (waited >= 20) begin
                checks++;
                failures++;
                $display("FAIL byte_accept: got no in_ready in 20 cycles, expected acceptance");
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_stream(input int count, input bit gaps, output int stalls);
        int w;
        stalls = 0;
        for (int i = 0; i < count; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
                repeat ($urandom_range(1, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_byte(stream[i], w);
            stalls += w;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic check_outcome(input string tag, input int outcome);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check({tag, "_done"}, 32'(done), 32'(outcome == 1));
        check({tag, "_error"}, 32'(error), 32'(outcome == 2));
        check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'(outcome == 1));
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'(outcome == 0));
        check({tag, "_busy"}, 32'(busy), 32'(outcome == 0));
        check({tag, "_writes_drained"}, 32'(exp_q.size()), 32'd0);
        // Terminal states must refuse further bytes and stay put.
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'($urandom);
        repeat (3) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_held_done"}, 32'(done), 32'(outcome == 1));
        check({tag, "_held_error"}, 32'(error), 32'(outcome == 2));
    endtask

    task automatic do_restart();
        @(posedge clk);
        #1;
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        @(negedge clk);
        check("restart_done", 32'(done), 32'd0);
        check("restart_error", 32'(error), 32'd0);
        check("restart_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check("restart_in_ready", 32'(bus.in_ready), 32'd1);
        check("restart_busy", 32'(busy), 32'd0);
    endtask

    task automatic run_stream(input string tag, input bit gaps);
        int outcome;
        int consumed;
        int stalls;
        model_push(outcome, consumed);
        send_stream(consumed, gaps, stalls);
        if (outcome != 0) check_outcome(tag, outcome);
    endtask

    task automatic set_req032(input logic [7:0] csum);
        stream = {8'h31, 8'h4F, 8'h43, 8'h50, 8'h02, 8'h00, 8'h00, 8'h00,
                  8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, csum};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int outcome;
        int consumed;
        int stalls;
        int unsigned n;
        int sel;

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Two-word load with a good checksum.
        set_req032(8'h7E);
        run_stream("load2", 1'b1);
        do_restart();

        // Header resync after a false start, empty image.
        stream = {8'h00, 8'h31, 8'h31, 8'h4F, 8'h43, 8'h50,
                  8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_stream("resync", 1'b1);
        do_restart();

        // Word count one above capacity.
        stream = {8'h31, 8'h4F, 8'h43, 8'h50, 8'h01, 8'h10, 8'h00, 8'h00};
        run_stream("too_long", 1'b1);
        do_restart();

        // Bad checksum: both words still written.
        set_req032(8'h7F);
        run_stream("bad_csum", 1'b1);
        do_restart();

        // Restart collides with the 3rd payload byte.
        stream = {8'h31, 8'h4F, 8'h43, 8'h50, 8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00};
        model_push(outcome, consumed);
        send_stream(consumed, 1'b0, stalls);
        @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h00;
        restart      = 1'b1;
        @(posedge clk);
        #1;
        restart      = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("restart_drop_busy", 32'(busy), 32'd0);
        check("restart_drop_in_ready", 32'(bus.in_ready), 32'd1);
        set_req032(8'h7E);
        run_stream("after_restart", 1'b1);
        do_restart();

        // Asynchronous reset in the middle of word 1.
        stream = {8'h31, 8'h4F, 8'h43, 8'h50, 8'h03, 8'h00, 8'h00, 8'h00,
                  8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
        model_push(outcome, consumed);
        send_stream(consumed, 1'b0, stalls);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_mem_we", 32'(bus.mem_we), 32'd0);
        check("arst_mem_addr", bus.mem_addr, 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("arst_writes_drained", 32'(exp_q.size()), 32'd0);
        set_req032(8'h7E);
        run_stream("after_reset", 1'b1);
        do_restart();

        // Sustained one byte per cycle.
        build_random(8, 1'b1, 0);
        model_push(outcome, consumed);
        we_cycles.delete();
        send_stream(consumed, 1'b0, stalls);
        check("b2b_stalls", 32'(stalls), 32'd0);
        check_outcome("b2b", outcome);
        check("b2b_write_count", 32'(we_cycles.size()), 32'd8);
        for (int i = 1; i < we_cycles.size(); i++) begin
            check("b2b_we_spacing", 32'(we_cycles[i] - we_cycles[i-1]), 32'd4);
        end
        do_restart();

        // Random images: sizes, checksums, garbage prefixes, gaps.
        for (int r = 0; r < 12; r++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0) n = 0;
            else if (sel == 1) n = WORDS + 1 + $urandom_range(0, 1000);
            else n = $urandom_range(1, 12);
            build_random(n, $urandom_range(0, 3) != 0, $urandom_range(0, 3));
            run_stream("random", 1'b1);
            do_restart();
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
